// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// read in flight, and presents each fetched word (or an exception) to decode.
// A misaligned PC or an access fault stops fetching until the next flush.
module fetch #(
  parameter int                ADDR_W      = 32,
  parameter int                INSTR_W     = 32,
  parameter int                EX_W        = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [EX_W-1:0]   EX_MISALIGN = 4'd0,
  parameter logic [EX_W-1:0]   EX_FAULT    = 4'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_error,
  output logic [ADDR_W-1:0]  PC_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [EX_W-1:0]    exception_out,
  output logic               exception_out_valid,
  output logic               pipeline_out_valid
);

  // Word presented in place of the missing instruction when the PC is misaligned.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] hold_data;
  logic               hold_error;

  logic               misaligned;
  logic               deliver;
  logic [INSTR_W-1:0] pres_data;
  logic               pres_error;

  assign misaligned = (pc[1:0] != 2'b00);

  // The request is a pure function of state so that address and valid stay
  // stable while memory withholds ready; it is suppressed in reset/flush cycles.
  assign imem_req_valid = (state == S_REQ) && !misaligned && !flush && !reset;
  assign imem_req_addr  = pc;

  // Select the word to present: the parked copy in HOLD, else the live response.
  always_comb begin
    pres_data  = imem_rsp_data;
    pres_error = imem_rsp_error;
    deliver    = 1'b0;
    if (state == S_HOLD) begin
      pres_data  = hold_data;
      pres_error = hold_error;
      deliver    = !stall;
    end else if (state == S_WAIT) begin
      deliver    = !stall && imem_rsp_valid;
    end else begin
      deliver    = 1'b0;
    end
  end

  // Fetch sequencer and decode-facing output registers (reset > flush > stall).
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_REQ;
      pc                  <= RESET_PC;
      hold_data           <= '0;
      hold_error          <= 1'b0;
      PC_out              <= '0;
      instr_out           <= '0;
      exception_out       <= '0;
      exception_out_valid <= 1'b0;
      pipeline_out_valid  <= 1'b0;
    end else if (flush) begin
      pc                  <= flush_pc;
      pipeline_out_valid  <= 1'b0;
      exception_out_valid <= 1'b0;
      // A read still owed by memory must be swallowed before fetching again.
      if ((state == S_WAIT || state == S_DRAIN) && !imem_rsp_valid) begin
        state <= S_DRAIN;
      end else begin
        state <= S_REQ;
      end
    end else begin
      // Decode samples every non-stall cycle, so valid is a one-cycle pulse.
      if (!stall) begin
        pipeline_out_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (misaligned) begin
            if (!stall) begin
              PC_out              <= pc;
              instr_out           <= NOP_INSTR;
              exception_out       <= EX_MISALIGN;
              exception_out_valid <= 1'b1;
              pipeline_out_valid  <= 1'b1;
              state               <= S_HALT;
            end
          end else if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT, S_HOLD: begin
          if (deliver) begin
            PC_out              <= pc;
            instr_out           <= pres_data;
            exception_out_valid <= pres_error;
            if (pres_error) begin
              exception_out <= EX_FAULT;
            end
            pipeline_out_valid  <= 1'b1;
            pc                  <= pc + ADDR_W'(4);
            state               <= pres_error ? S_HALT : S_REQ;
          end else if (state == S_WAIT && imem_rsp_valid) begin
            hold_data  <= imem_rsp_data;
            hold_error <= imem_rsp_error;
            state      <= S_HOLD;
          end
        end
        S_DRAIN: begin
          if (imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a memory model with random latency/ready and
// an instruction-stream scoreboard derived from address arithmetic alone.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready, imem_rsp_valid, imem_rsp_error;
  logic [31:0] imem_rsp_data;
  logic [31:0] PC_out, instr_out;
  logic [3:0]  exception_out;
  logic        exception_out_valid, pipeline_out_valid;

  always #5 clk = ~clk;

  fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_error(imem_rsp_error),
    .PC_out(PC_out), .instr_out(instr_out), .exception_out(exception_out),
    .exception_out_valid(exception_out_valid), .pipeline_out_valid(pipeline_out_valid)
  );

  int errors = 0;
  int checks = 0;

  // memory model state
  bit          outst;
  int          lat;
  logic [31:0] out_addr;
  int          min_lat, max_lat;
  bit          const_data, force_err, rand_err;
  logic [31:0] err_addr, salt;
  // scoreboard state
  logic [31:0] fp;       // next address the stage should request
  logic [31:0] exp_pc;   // next PC the stage should present
  bit          halted;
  int          presented;
  bit          last_req;
  logic [31:0] last_req_addr;
  logic        prev_v, prev_ev;
  logic [31:0] prev_pc, prev_instr;
  logic [3:0]  prev_ex;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ salt;
    return const_data ? 32'h0050_0093 : h;
  endfunction

  function automatic logic merr(input logic [31:0] a);
    logic [31:0] h;
    h = (a ^ salt) * 32'h85EB_CA6B;
    if (force_err) return (a == err_addr);
    else if (rand_err) return (h[31:28] == 4'h0);
    else return 1'b0;
  endfunction

  task automatic snapshot();
    prev_v = pipeline_out_valid; prev_ev = exception_out_valid;
    prev_pc = PC_out; prev_instr = instr_out; prev_ex = exception_out;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; imem_rsp_error = 1'b0;
    #1;
    check_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    @(posedge clk); #1;
    check_eq("rst_valid", {31'h0, pipeline_out_valid}, 32'h0);
    check_eq("rst_exc_valid", {31'h0, exception_out_valid}, 32'h0);
    check_eq("rst_pc", PC_out, 32'h0);
    check_eq("rst_instr", instr_out, 32'h0);
    check_eq("rst_exc", {28'h0, exception_out}, 32'h0);
    reset = 1'b0;
    outst = 1'b0; fp = 32'h0; exp_pc = 32'h0; halted = 1'b0;
    snapshot();
  endtask

  // One clock cycle: drive inputs, check the request, clock, check outputs.
  task automatic cyc(input bit st, input bit fl, input logic [31:0] fpc, input bit rdy);
    bit          rsp, acc, e;
    stall = st; flush = fl; flush_pc = fpc; imem_req_ready = rdy;
    rsp = outst && (lat == 0);
    imem_rsp_valid = rsp;
    if (rsp) begin
      imem_rsp_data = mdata(out_addr); imem_rsp_error = merr(out_addr);
    end else begin
      imem_rsp_data = $urandom; imem_rsp_error = 1'($urandom_range(0, 1));
    end
    #1;
    last_req = imem_req_valid; last_req_addr = imem_req_addr;
    if (fl) check_eq("req_in_flush", {31'h0, imem_req_valid}, 32'h0);
    if (imem_req_valid) begin
      check_eq("req_single", {31'h0, outst}, 32'h0);
      check_eq("req_halted", {31'h0, halted}, 32'h0);
      check_eq("req_addr", imem_req_addr, fp);
    end
    acc = imem_req_valid && rdy;
    @(posedge clk); #1;
    if (rsp) outst = 1'b0;
    else if (outst) lat--;
    if (acc) begin
      outst = 1'b1; lat = $urandom_range(min_lat, max_lat);
      out_addr = last_req_addr; fp = fp + 32'd4;
    end
    if (fl) begin fp = fpc; exp_pc = fpc; halted = 1'b0; end
    if (fl) begin
      check_eq("flush_valid", {31'h0, pipeline_out_valid}, 32'h0);
      check_eq("flush_exc_valid", {31'h0, exception_out_valid}, 32'h0);
    end else if (st) begin
      check_eq("stall_valid", {31'h0, pipeline_out_valid}, {31'h0, prev_v});
      check_eq("stall_exc_valid", {31'h0, exception_out_valid}, {31'h0, prev_ev});
      check_eq("stall_pc", PC_out, prev_pc);
      check_eq("stall_instr", instr_out, prev_instr);
      check_eq("stall_exc", {28'h0, exception_out}, {28'h0, prev_ex});
    end else if (pipeline_out_valid) begin
      presented++;
      check_eq("out_pc", PC_out, exp_pc);
      if (exp_pc[1:0] != 2'b00) begin
        check_eq("out_instr", instr_out, 32'h0000_0013);
        check_eq("out_exc_valid", {31'h0, exception_out_valid}, 32'h1);
        check_eq("out_exc", {28'h0, exception_out}, 32'h0);
        halted = 1'b1;
      end else begin
        e = merr(exp_pc);
        check_eq("out_instr", instr_out, mdata(exp_pc));
        check_eq("out_exc_valid", {31'h0, exception_out_valid}, {31'h0, e});
        if (e) begin
          check_eq("out_exc", {28'h0, exception_out}, 32'h1);
          halted = 1'b1;
        end
      end
      exp_pc = exp_pc + 32'd4;
    end
    snapshot();
  endtask

  initial begin
    bit          found;
    bit          st, fl, rdy;
    logic [31:0] fpc;
    const_data = 1'b1; force_err = 1'b0; rand_err = 1'b0;
    min_lat = 0; max_lat = 0; salt = $urandom; err_addr = 32'h0;
    presented = 0; lat = 0; out_addr = 32'h0;

    // zero-wait memory: one instruction every second cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("tput_valid", {31'h0, pipeline_out_valid}, (i % 2 == 1) ? 32'h1 : 32'h0);
    end

    // stall while the response for PC 4 arrives
    do_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      check_eq("hold_noreq", {31'h0, last_req}, 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("hold_noreq", {31'h0, last_req}, 32'h0);
    check_eq("hold_emit_valid", {31'h0, pipeline_out_valid}, 32'h1);
    check_eq("hold_emit_pc", PC_out, 32'h4);

    // flush while waiting for PC 8: that response is dropped
    min_lat = 2; max_lat = 2;
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h100, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (last_req) found = 1'b1;
    end
    check_eq("redirect_seen", {31'h0, found}, 32'h1);
    if (found) check_eq("redirect_addr", last_req_addr, 32'h100);
    min_lat = 0; max_lat = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (pipeline_out_valid) found = 1'b1;
    end
    check_eq("redirect_present", {31'h0, found}, 32'h1);

    // misaligned redirect target
    cyc(1'b0, 1'b1, 32'h102, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("mis_valid", {31'h0, pipeline_out_valid}, 32'h1);
    check_eq("mis_exc", {27'h0, exception_out_valid, exception_out}, 32'h10);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("mis_halt_noreq", {31'h0, last_req}, 32'h0);
    end

    // access fault at PC 0xC
    const_data = 1'b0; force_err = 1'b1; err_addr = 32'hC;
    cyc(1'b0, 1'b1, 32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (pipeline_out_valid && PC_out == 32'hC) found = 1'b1;
    end
    check_eq("fault_seen", {31'h0, found}, 32'h1);
    check_eq("fault_exc", {27'h0, exception_out_valid, exception_out}, 32'h11);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("fault_halt_noreq", {31'h0, last_req}, 32'h0);
    end

    // ready held low: request must stay put; then flush+stall together
    force_err = 1'b0;
    cyc(1'b0, 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      check_eq("rdy_low_valid", {31'h0, last_req}, 32'h1);
      check_eq("rdy_low_addr", last_req_addr, 32'h40);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("pre_flush_valid", {31'h0, pipeline_out_valid}, 32'h1);
    cyc(1'b1, 1'b1, 32'h80, 1'b1);
    check_eq("flush_stall_valid", {31'h0, pipeline_out_valid}, 32'h0);

    // randomized traffic
    rand_err = 1'b1; min_lat = 0; max_lat = 3; presented = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      st  = ($urandom % 4) == 0;
      fl  = ($urandom % 25) == 0;
      rdy = ($urandom % 3) != 0;
      fpc = 32'($urandom_range(0, 1023));
      if (($urandom % 8) != 0) fpc = fpc & 32'hFFFF_FFFC;
      if (($urandom % 50) == 0) fpc = 32'hFFFF_FFFC;
      cyc(st, fl, fpc, rdy);
    end
    check_eq("progress", {31'h0, (presented > 200)}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
